bc_branch_resolver: RTL and testbench

Execute stage for the conditional branch (bc, decoded opcode 25), directly downstream of the B-form decoder. It accepts the decoder's 28-bit B-form body and instruction header. It owns the architected CTR and LR, evaluates the BO/BI condition against a CR snapshot, computes the branch target, and emits a registered redirect to the fetch unit and a completion record to reorder logic.

---
 rtl/bc_branch_resolver_pkg.sv | 68 ++++++
 rtl/bc_branch_resolver_condition_eval.sv | 46 ++++
 rtl/bc_branch_resolver.sv | 185 ++++++++++++++++++
 tb/tb_bc_branch_resolver.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bc_branch_resolver_pkg.sv
// -----------------------------------------------------------------------------
// bc_branch_resolver_pkg
//
// Shared definitions for the conditional-branch (bc) execute stage. It holds
// the B-form body layout, the BO control bit positions, the accepted unit code
// and opcode, the 32-bit mode address mask, and a small decode helper.
//
// Bit numbering note: the architecture numbers fields big-endian, so IBM bit 0
// is the MSB. The 28-bit body arrives as logic [27:0]. IBM bit j of the body
// therefore lives at vector index 27-j. The same mapping applies to the 32-bit
// CR snapshot, where IBM bit n is vector index 31-n.
// -----------------------------------------------------------------------------
package bc_branch_resolver_pkg;

  // Accepted unit code and decoded opcode.
  localparam int BRANCH_UNIT_ID = 6;
  localparam int BC_OPCODE      = 25;

  // B-form body layout as vector indices of a logic [27:0].
  // The fields are BO = IBM[0:4], BI = IBM[5:9], BD = IBM[10:23],
  // 00 = IBM[24:25], AA = IBM[26] and LK = IBM[27].
  localparam int BODY_WIDTH = 28;
  localparam int BO_MSB     = 27;
  localparam int BO_LSB     = 23;
  localparam int BI_MSB     = 22;
  localparam int BI_LSB     = 18;
  // BD together with the two trailing zero bits forms BD||00, the 16-bit
  // byte displacement. It is taken as one field.
  localparam int DISP_MSB   = 17;
  localparam int DISP_LSB   = 2;
  localparam int AA_BIT     = 1;
  localparam int LK_BIT     = 0;

  // BO control bits BO[0:3], packed MSB-first into a logic [3:0].
  // BO[4] is only a static prediction hint, and resolution does not use it.
  localparam int BO_IGNORE_COND = 3;  // BO[0]: skip the CR test
  localparam int BO_COND_SENSE  = 2;  // BO[1]: required CR bit value
  localparam int BO_NO_DECR     = 1;  // BO[2]: leave CTR alone
  localparam int BO_CTR_SENSE   = 0;  // BO[3]: 1 = branch when CTR==0

  // The upper word of an address is cleared in 32-bit mode.
  localparam logic [63:0] MODE32_ADDR_MASK = 64'h0000_0000_FFFF_FFFF;

  // Decoded B-form fields as they are held in the stage-1 register.
  typedef struct packed {
    logic [3:0]  bo_ctl;
    logic [4:0]  bi;
    logic [15:0] disp_field;
    logic        aa;
    logic        lk;
  } bform_t;

  function automatic bform_t decode_bform(input logic [BODY_WIDTH-1:0] body);
    bform_t f;
    f.bo_ctl     = body[BO_MSB:BO_LSB+1];
    f.bi         = body[BI_MSB:BI_LSB];
    f.disp_field = body[DISP_MSB:DISP_LSB];
    f.aa         = body[AA_BIT];
    f.lk         = body[LK_BIT];
    return f;
  endfunction

  // Sign-extend BD||00 to a full 64-bit displacement.
  function automatic logic [63:0] bform_displacement(input logic [15:0] disp_field);
    return {{48{disp_field[15]}}, disp_field};
  endfunction

endpackage

// File: rtl/bc_branch_resolver_condition_eval.sv
// -----------------------------------------------------------------------------
// bc_condition_eval
//
// Purely combinational BO/BI evaluation. It is shared with the future
// bclr/bcctr resolver. It produces the decremented CTR and the taken
// decision.
//
// Ports:
//   bo        in  4   BO[0:3] control bits (MSB = BO[0])
//   bi        in  5   CR bit selector, IBM numbering
//   cr        in  32  CR snapshot; IBM bit n is vector index 31-n
//   eff_ctr   in  64  CTR value after same-cycle write forwarding
//   is_64bit  in  1   64-bit mode; in 32-bit mode only CTR[32:63] is tested
//   new_ctr   out 64  eff_ctr-1 when BO[2]==0, otherwise eff_ctr
//   taken     out 1   branch outcome
// -----------------------------------------------------------------------------
module bc_condition_eval
  import bc_branch_resolver_pkg::*;
(
  input  logic [3:0]  bo,
  input  logic [4:0]  bi,
  input  logic [31:0] cr,
  input  logic [63:0] eff_ctr,
  input  logic        is_64bit,
  output logic [63:0] new_ctr,
  output logic        taken
);

  logic [63:0] ctr_masked;
  logic [4:0]  cr_index;
  logic        ctr_ok;
  logic        cond_ok;

  always_comb begin
    // The subtraction wraps naturally, so 0 becomes all-ones.
    new_ctr    = bo[BO_NO_DECR] ? eff_ctr : eff_ctr - 64'd1;
    ctr_masked = is_64bit ? new_ctr : {32'd0, new_ctr[31:0]};
    ctr_ok     = bo[BO_NO_DECR] | ((ctr_masked != 64'd0) ^ bo[BO_CTR_SENSE]);

    cr_index   = 5'd31 - bi;
    cond_ok    = bo[BO_IGNORE_COND] | (cr[cr_index] == bo[BO_COND_SENSE]);

    taken      = ctr_ok & cond_ok;
  end

endmodule

// File: rtl/bc_branch_resolver.sv
// -----------------------------------------------------------------------------
// bc_branch_resolver
//
// Execute stage for the conditional branch bc. A matching instruction from the
// B-form decoder is captured into stage-1 register S1. On the following
// unstalled edge the condition and target are resolved from S1. The result is
// registered onto the outputs as a one-cycle enable_o pulse. CTR and LR are
// updated on the same edge. This block owns the architected CTR and LR.
// mtspr writes reach them through sprWrite_i.
//
// Ports:
//   clock_i, reset_i         clock; asynchronous active-high reset
//   enable_i, stall_i        decoder valid; pipeline stall
//   opcode_i,
//   functionalUnitType_i     accept only BcOpcode on BranchUnitID
//   instructionAddress_i     CIA
//   instMajId_i              major ID, carried through to instMajId_o
//   is64Bit_i                64-bit mode
//   instructionBody_i        28-bit B-form body (BO BI BD 00 AA LK)
//   cr_i                     CR snapshot (IBM bit n = CR bit n+32)
//   sprWrite_i, sprSelLr_i,
//   sprData_i                mtspr write to LR (sel=1) or CTR (sel=0)
//   enable_o                 result valid pulse
//   taken_o                  branch outcome
//   redirectAddress_o        target if taken, else CIA+4
//   instMajId_o              major ID of the result
//   ctr_o, lr_o              architected CTR and LR
// -----------------------------------------------------------------------------
module bc_branch_resolver
  import bc_branch_resolver_pkg::*;
#(
  parameter int addressWidth            = 64,
  parameter int instructionCounterWidth = 64,
  parameter int opcodeSize              = 12,
  parameter int funcUnitCodeSize        = 3,
  parameter int BranchUnitID            = BRANCH_UNIT_ID,
  parameter int BcOpcode                = BC_OPCODE
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               enable_i,
  input  logic                               stall_i,
  input  logic [opcodeSize-1:0]              opcode_i,
  input  logic [funcUnitCodeSize-1:0]        functionalUnitType_i,
  input  logic [addressWidth-1:0]            instructionAddress_i,
  input  logic [instructionCounterWidth:0]   instMajId_i,
  input  logic                               is64Bit_i,
  input  logic [BODY_WIDTH-1:0]              instructionBody_i,
  input  logic [31:0]                        cr_i,
  input  logic                               sprWrite_i,
  input  logic                               sprSelLr_i,
  input  logic [63:0]                        sprData_i,
  output logic                               enable_o,
  output logic                               taken_o,
  output logic [addressWidth-1:0]            redirectAddress_o,
  output logic [instructionCounterWidth:0]   instMajId_o,
  output logic [63:0]                        ctr_o,
  output logic [63:0]                        lr_o
);

  // Stage-1 register holding the accepted instruction.
  logic                              s1_valid;
  logic [addressWidth-1:0]           s1_cia;
  logic [instructionCounterWidth:0]  s1_maj_id;
  logic                              s1_is_64bit;
  bform_t                            s1_form;
  logic [31:0]                       s1_cr;

  // Architected special-purpose registers.
  logic [63:0] ctr_q;
  logic [63:0] lr_q;

  logic                    accept;
  logic                    emit;
  logic                    ctr_spr_write;
  logic                    lr_spr_write;
  logic [63:0]             eff_ctr;
  logic [63:0]             new_ctr;
  logic                    taken;
  logic [addressWidth-1:0] mode_mask;
  logic [addressWidth-1:0] disp;
  logic [addressWidth-1:0] target_raw;
  logic [addressWidth-1:0] next_raw;
  logic [addressWidth-1:0] target_addr;
  logic [addressWidth-1:0] link_addr;
  logic [addressWidth-1:0] redirect_next;

  assign accept = enable_i && !stall_i
                  && (opcode_i == opcodeSize'(BcOpcode))
                  && (functionalUnitType_i == funcUnitCodeSize'(BranchUnitID));

  // S1 drains only on an unstalled edge.
  assign emit = s1_valid && !stall_i;

  assign ctr_spr_write = sprWrite_i && !sprSelLr_i;
  assign lr_spr_write  = sprWrite_i &&  sprSelLr_i;

  // A CTR write in the same cycle is forwarded into the emitting bc.
  // Without it, that bc would read the stale value.
  assign eff_ctr = ctr_spr_write ? sprData_i : ctr_q;

  bc_condition_eval u_condition_eval (
    .bo       (s1_form.bo_ctl),
    .bi       (s1_form.bi),
    .cr       (s1_cr),
    .eff_ctr  (eff_ctr),
    .is_64bit (s1_is_64bit),
    .new_ctr  (new_ctr),
    .taken    (taken)
  );

  // Target and fall-through address. In 32-bit mode both addresses are
  // truncated to the low word.
  always_comb begin
    mode_mask     = addressWidth'(MODE32_ADDR_MASK);
    disp          = addressWidth'(bform_displacement(s1_form.disp_field));
    target_raw    = s1_form.aa ? disp : s1_cia + disp;
    next_raw      = s1_cia + addressWidth'(4);
    target_addr   = s1_is_64bit ? target_raw : (target_raw & mode_mask);
    link_addr     = s1_is_64bit ? next_raw   : (next_raw   & mode_mask);
    redirect_next = taken ? target_addr : link_addr;
  end

  // Pipeline: S1 capture and the registered result. A stall freezes S1 and
  // suppresses the pulse. The other outputs keep their last value.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      s1_valid          <= 1'b0;
      s1_cia            <= '0;
      s1_maj_id         <= '0;
      s1_is_64bit       <= 1'b0;
      s1_form           <= '0;
      s1_cr             <= '0;
      enable_o          <= 1'b0;
      taken_o           <= 1'b0;
      redirectAddress_o <= '0;
      instMajId_o       <= '0;
    end else if (stall_i) begin
      enable_o <= 1'b0;
    end else begin
      enable_o <= s1_valid;
      if (s1_valid) begin
        taken_o           <= taken;
        redirectAddress_o <= redirect_next;
        instMajId_o       <= s1_maj_id;
      end
      // S1 is refilled or cleared on every unstalled edge. An emitted
      // instruction therefore cannot emit a second time.
      s1_valid <= accept;
      if (accept) begin
        s1_cia      <= instructionAddress_i;
        s1_maj_id   <= instMajId_i;
        s1_is_64bit <= is64Bit_i;
        s1_form     <= decode_bform(instructionBody_i);
        s1_cr       <= cr_i;
      end
    end
  end

  // CTR/LR update. On the emit edge the bc result takes priority over an
  // mtspr to the same register. The other register still accepts the mtspr.
  // LR is linked whenever LK=1, whether or not the branch is taken.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      ctr_q <= '0;
      lr_q  <= '0;
    end else begin
      if (emit && !s1_form.bo_ctl[BO_NO_DECR]) begin
        ctr_q <= new_ctr;
      end else if (ctr_spr_write) begin
        ctr_q <= sprData_i;
      end

      if (emit && s1_form.lk) begin
        lr_q <= 64'(link_addr);
      end else if (lr_spr_write) begin
        lr_q <= sprData_i;
      end
    end
  end

  assign ctr_o = ctr_q;
  assign lr_o  = lr_q;

endmodule

// File: tb/tb_bc_branch_resolver.sv
// -----------------------------------------------------------------------------
// tb_bc_branch_resolver
//
// Scoreboard bench for bc_branch_resolver. The driver applies one set of
// inputs per cycle. A reference model then predicts what the next edge
// produces and queues an expected result whenever a bc emits on that edge. The
// monitor runs on the falling edge, pops one entry per enable_o pulse and
// compares it. The model reads fields in architectural (IBM) bit numbering.
// -----------------------------------------------------------------------------
module tb_bc_branch_resolver;

  localparam logic [63:0] LOW_WORD = 64'h0000_0000_FFFF_FFFF;

  logic         clock_i = 1'b0;
  logic         reset_i;
  logic         enable_i;
  logic         stall_i;
  logic [11:0]  opcode_i;
  logic [2:0]   functionalUnitType_i;
  logic [63:0]  instructionAddress_i;
  logic [64:0]  instMajId_i;
  logic         is64Bit_i;
  logic [27:0]  instructionBody_i;
  logic [31:0]  cr_i;
  logic         sprWrite_i;
  logic         sprSelLr_i;
  logic [63:0]  sprData_i;
  logic         enable_o;
  logic         taken_o;
  logic [63:0]  redirectAddress_o;
  logic [64:0]  instMajId_o;
  logic [63:0]  ctr_o;
  logic [63:0]  lr_o;

  bc_branch_resolver #(
    .addressWidth            (64),
    .instructionCounterWidth (64),
    .opcodeSize              (12),
    .funcUnitCodeSize        (3),
    .BranchUnitID            (6),
    .BcOpcode                (25)
  ) dut (
    .clock_i              (clock_i),
    .reset_i              (reset_i),
    .enable_i             (enable_i),
    .stall_i              (stall_i),
    .opcode_i             (opcode_i),
    .functionalUnitType_i (functionalUnitType_i),
    .instructionAddress_i (instructionAddress_i),
    .instMajId_i          (instMajId_i),
    .is64Bit_i            (is64Bit_i),
    .instructionBody_i    (instructionBody_i),
    .cr_i                 (cr_i),
    .sprWrite_i           (sprWrite_i),
    .sprSelLr_i           (sprSelLr_i),
    .sprData_i            (sprData_i),
    .enable_o             (enable_o),
    .taken_o              (taken_o),
    .redirectAddress_o    (redirectAddress_o),
    .instMajId_o          (instMajId_o),
    .ctr_o                (ctr_o),
    .lr_o                 (lr_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [64:0] id;
    logic        taken;
    logic [63:0] redirect;
    logic [63:0] ctr;
    logic [63:0] lr;
    int          edge_no;
  } expect_t;

  expect_t expectQ[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [64:0] nextId = 65'd1;

  // Reference model state.
  logic [63:0] mCtr = 64'd0;
  logic [63:0] mLr  = 64'd0;
  bit          mPend = 1'b0;
  logic [63:0] mCia;
  logic [64:0] mId;
  bit          mIs64;
  logic [27:0] mBody;
  logic [31:0] mCr;

  always @(posedge clock_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reads architectural bits first..last of the body as an unsigned number.
  function automatic int ibmField(input logic [27:0] body, input int first, input int last);
    int v = 0;
    for (int j = first; j <= last; j++) v = v * 2 + int'(body[27 - j]);
    return v;
  endfunction

  function automatic logic [27:0] mkBody(input logic [4:0] bo, input logic [4:0] bi,
                                         input logic [13:0] bd, input logic aa,
                                         input logic lk);
    return {bo, bi, bd, 2'b00, aa, lk};
  endfunction

  // Predicts the effect of the next edge for the inputs currently driven.
  task automatic modelEdge(input bit en, input bit stall, input logic [11:0] op,
                           input logic [2:0] fu, input logic [63:0] cia,
                           input logic [64:0] id, input bit is64,
                           input logic [27:0] body, input logic [31:0] cr,
                           input bit sprWr, input bit sprLr, input logic [63:0] sprData);
    logic [63:0] nextCtr = mCtr;
    logic [63:0] nextLr  = mLr;
    if (sprWr) begin
      if (sprLr) nextLr = sprData;
      else       nextCtr = sprData;
    end
    if (mPend && !stall) begin
      expect_t e;
      logic [63:0] ctrIn, ctrDec, ctrTest, disp, target, nia;
      int bd;
      bit decrement, ctrOk, condOk, crBit;
      ctrIn     = (sprWr && !sprLr) ? sprData : mCtr;
      decrement = (ibmField(mBody, 2, 2) == 0);
      ctrDec    = decrement ? ctrIn - 64'd1 : ctrIn;
      ctrTest   = mIs64 ? ctrDec : (ctrDec & LOW_WORD);
      ctrOk     = !decrement || ((ctrTest != 0) != (ibmField(mBody, 3, 3) == 1));
      crBit     = mCr[31 - ibmField(mBody, 5, 9)];
      condOk    = (ibmField(mBody, 0, 0) == 1) || (int'(crBit) == ibmField(mBody, 1, 1));
      bd        = ibmField(mBody, 10, 23);
      if (bd >= 8192) bd = bd - 16384;
      disp      = 64'(longint'(bd) * 4);
      target    = (ibmField(mBody, 26, 26) == 1) ? disp : mCia + disp;
      nia       = mCia + 64'd4;
      if (!mIs64) begin
        target = target & LOW_WORD;
        nia    = nia & LOW_WORD;
      end
      if (decrement) nextCtr = ctrDec;
      if (ibmField(mBody, 27, 27) == 1) nextLr = nia;
      e.id       = mId;
      e.taken    = ctrOk && condOk;
      e.redirect = e.taken ? target : nia;
      e.ctr      = nextCtr;
      e.lr       = nextLr;
      e.edge_no  = cyc + 1;
      expectQ.push_back(e);
    end
    mCtr = nextCtr;
    mLr  = nextLr;
    if (!stall) begin
      mPend = en && (op == 12'd25) && (fu == 3'd6);
      mCia  = cia;
      mId   = id;
      mIs64 = is64;
      mBody = body;
      mCr   = cr;
    end
  endtask

  // Drives one cycle of inputs and returns 2 time units after the edge.
  task automatic applyStimulus(input bit en, input bit stall, input logic [11:0] op,
                               input logic [2:0] fu, input logic [63:0] cia,
                               input logic [64:0] id, input bit is64,
                               input logic [27:0] body, input logic [31:0] cr,
                               input bit sprWr, input bit sprLr, input logic [63:0] sprData);
    enable_i             = en;
    stall_i              = stall;
    opcode_i             = op;
    functionalUnitType_i = fu;
    instructionAddress_i = cia;
    instMajId_i          = id;
    is64Bit_i            = is64;
    instructionBody_i    = body;
    cr_i                 = cr;
    sprWrite_i           = sprWr;
    sprSelLr_i           = sprLr;
    sprData_i            = sprData;
    if (!reset_i) modelEdge(en, stall, op, fu, cia, id, is64, body, cr, sprWr, sprLr, sprData);
    @(posedge clock_i);
    #2;
  endtask

  task automatic bc(input logic [63:0] cia, input bit is64, input logic [27:0] body,
                    input logic [31:0] cr);
    applyStimulus(1'b1, 1'b0, 12'd25, 3'd6, cia, nextId, is64, body, cr, 1'b0, 1'b0, 64'd0);
    nextId++;
  endtask

  task automatic idle(input bit sprWr, input bit sprLr, input logic [63:0] sprData);
    applyStimulus(1'b0, 1'b0, 12'd0, 3'd0, 64'd0, 65'd0, 1'b1, 28'd0, 32'd0,
                  sprWr, sprLr, sprData);
  endtask

  task automatic stallCycle();
    applyStimulus(1'b0, 1'b1, 12'd0, 3'd0, 64'd0, 65'd0, 1'b1, 28'd0, 32'd0,
                  1'b0, 1'b0, 64'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " enable_o"}, enable_o, 0);
    checkOutput({tag, " taken_o"}, taken_o, 0);
    checkOutput({tag, " redirect"}, redirectAddress_o, 0);
    checkOutput({tag, " instMajId_o"}, instMajId_o, 0);
    checkOutput({tag, " ctr_o"}, ctr_o, 0);
    checkOutput({tag, " lr_o"}, lr_o, 0);
  endtask

  // Monitor: one scoreboard entry per result pulse.
  always @(negedge clock_i) begin
    if (enable_o === 1'b1) begin
      if (expectQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result: got enable_o id 0x%0h expected no result",
                 instMajId_o);
      end else begin
        expect_t e;
        e = expectQ.pop_front();
        checkOutput("sb edge", 128'(cyc), 128'(e.edge_no));
        checkOutput("sb id", instMajId_o, e.id);
        checkOutput("sb taken", taken_o, e.taken);
        checkOutput("sb redirect", redirectAddress_o, e.redirect);
        checkOutput("sb ctr", ctr_o, e.ctr);
        checkOutput("sb lr", lr_o, e.lr);
      end
    end
  end

  initial begin
    reset_i = 1'b1;
    enable_i = 1'b0; stall_i = 1'b0; opcode_i = '0; functionalUnitType_i = '0;
    instructionAddress_i = '0; instMajId_i = '0; is64Bit_i = 1'b1;
    instructionBody_i = '0; cr_i = '0; sprWrite_i = 1'b0; sprSelLr_i = 1'b0; sprData_i = '0;
    repeat (2) @(posedge clock_i);
    #2;
    checkResetState("reset");
    reset_i = 1'b0;

    // Taken, decrement 3 -> 2, relative target 0x1000+0x10.
    idle(1'b1, 1'b0, 64'd3);
    bc(64'h1000, 1'b1, mkBody(5'b10000, 5'd0, 14'h0004, 1'b0, 1'b0), 32'd0);
    idle(1'b0, 1'b0, 64'd0);
    checkOutput("t1 enable_o", enable_o, 1);
    checkOutput("t1 taken_o", taken_o, 1);
    checkOutput("t1 redirect", redirectAddress_o, 64'h1010);
    checkOutput("t1 ctr", ctr_o, 64'd2);

    // Decrement to zero, not taken; then wrap 0 -> all-ones.
    idle(1'b1, 1'b0, 64'd1);
    bc(64'h1000, 1'b1, mkBody(5'b10000, 5'd0, 14'h0004, 1'b0, 1'b0), 32'd0);
    idle(1'b0, 1'b0, 64'd0);
    checkOutput("t2 taken_o", taken_o, 0);
    checkOutput("t2 redirect", redirectAddress_o, 64'h1004);
    checkOutput("t2 ctr", ctr_o, 64'd0);
    bc(64'h1000, 1'b1, mkBody(5'b10010, 5'd0, 14'h0004, 1'b0, 1'b0), 32'd0);
    idle(1'b0, 1'b0, 64'd0);
    checkOutput("t2 wrap ctr", ctr_o, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("t2 wrap taken_o", taken_o, 0);

    // 32-bit mode only tests the low word of CTR.
    idle(1'b1, 1'b0, 64'h1_0000_0001);
    bc(64'h1000, 1'b0, mkBody(5'b10010, 5'd0, 14'h0004, 1'b0, 1'b0), 32'd0);
    idle(1'b0, 1'b0, 64'd0);
    checkOutput("t3 taken_o", taken_o, 1);
    checkOutput("t3 ctr", ctr_o, 64'h1_0000_0000);

    // CR test with no CTR decrement; then an absolute negative target with link.
    idle(1'b1, 1'b0, 64'h55);
    bc(64'h1000, 1'b1, mkBody(5'b01100, 5'd2, 14'h0004, 1'b0, 1'b0), 32'h2000_0000);
    idle(1'b0, 1'b0, 64'd0);
    checkOutput("t4 taken_o", taken_o, 1);
    checkOutput("t4 ctr", ctr_o, 64'h55);
    bc(64'h4000, 1'b1, mkBody(5'b01100, 5'd2, 14'h3FFF, 1'b1, 1'b1), 32'h2000_0000);
    idle(1'b0, 1'b0, 64'd0);
    checkOutput("t4 redirect", redirectAddress_o, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("t4 lr", lr_o, 64'h4004);

    // Back-to-back with a two-cycle stall while S1 is full.
    idle(1'b1, 1'b0, 64'd5);
    for (int i = 0; i < 2; i++)
      bc(64'h8000 + 64'(i * 4), 1'b1, mkBody(5'b00000, 5'd0, 14'h0010, 1'b0, 1'b0), 32'd0);
    stallCycle();
    stallCycle();
    for (int i = 2; i < 4; i++)
      bc(64'h8000 + 64'(i * 4), 1'b1, mkBody(5'b00000, 5'd0, 14'h0010, 1'b0, 1'b0), 32'd0);
    idle(1'b0, 1'b0, 64'd0);
    idle(1'b0, 1'b0, 64'd0);
    checkOutput("t5 ctr", ctr_o, 64'd1);

    // mtspr collisions on the emit edge.
    idle(1'b1, 1'b0, 64'd0);
    bc(64'h1000, 1'b1, mkBody(5'b10000, 5'd0, 14'h0004, 1'b0, 1'b0), 32'd0);
    idle(1'b1, 1'b0, 64'd7);
    checkOutput("t6 ctr fwd", ctr_o, 64'd6);
    bc(64'h2000, 1'b1, mkBody(5'b10100, 5'd0, 14'h0004, 1'b0, 1'b1), 32'd0);
    idle(1'b1, 1'b1, 64'h1234_5678);
    checkOutput("t6 lr", lr_o, 64'h2004);
    bc(64'h3000, 1'b1, mkBody(5'b10100, 5'd0, 14'h0004, 1'b0, 1'b1), 32'd0);
    idle(1'b1, 1'b0, 64'd9);
    checkOutput("t6 other ctr", ctr_o, 64'd9);
    checkOutput("t6 other lr", lr_o, 64'h3004);

    // Asynchronous reset between the accept and emit edges.
    bc(64'h5000, 1'b1, mkBody(5'b10100, 5'd0, 14'h0004, 1'b0, 1'b1), 32'd0);
    #1 reset_i = 1'b1;
    #1;
    checkResetState("midreset");
    mPend = 1'b0;
    mCtr  = 64'd0;
    mLr   = 64'd0;
    idle(1'b0, 1'b0, 64'd0);
    reset_i = 1'b0;
    idle(1'b0, 1'b0, 64'd0);
    checkResetState("postreset");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      bit st, en, is64, wr, sel;
      logic [11:0] op;
      logic [2:0] fu;
      logic [63:0] cia, data;
      int pick;
      st   = ($urandom_range(0, 9) == 0);
      en   = ($urandom_range(0, 3) != 0);
      op   = ($urandom_range(0, 7) == 0) ? 12'd24 : 12'd25;
      fu   = ($urandom_range(0, 7) == 0) ? 3'd5 : 3'd6;
      cia  = {$urandom, $urandom} & ~64'd3;
      is64 = 1'($urandom_range(0, 1));
      wr   = ($urandom_range(0, 4) == 0);
      sel  = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 4);
      case (pick)
        0:       data = 64'd0;
        1:       data = 64'd1;
        2:       data = 64'h1_0000_0001;
        default: data = {$urandom, $urandom};
      endcase
      applyStimulus(en, st, op, fu, cia, nextId, is64,
                    mkBody(5'($urandom), 5'($urandom), 14'($urandom), 1'($urandom),
                           1'($urandom)),
                    $urandom, wr, sel, data);
      nextId++;
    end
    repeat (3) idle(1'b0, 1'b0, 64'd0);

    checkOutput("pending results", 128'(expectQ.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
